tdc_pair_sched: RTL



---
 rtl/tdc_sched_pkg.sv | 14 +
 rtl/tdc_pair_sched_rr_arbiter.sv | 35 +++
 rtl/tdc_pair_sched.sv | 122 ++++++++++++
 3 files changed

// File: rtl/tdc_sched_pkg.sv
// Shared types and defaults for the TDC pair scheduler.
package tdc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        ISSUE  = 2'd2
    } state_t;

    localparam int DW_DEF     = 20;
    localparam int TO_CYC_DEF = 50000;
    localparam int CNT_W      = 16;

endpackage

// File: rtl/tdc_pair_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, cyclic.
module rr_arbiter #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]         req,
    input  logic [$clog2(N_CH)-1:0] ptr,
    output logic [N_CH-1:0]         gnt,
    output logic [$clog2(N_CH)-1:0] gnt_idx,
    output logic                    any
);
    localparam int IW = $clog2(N_CH);

    logic [2*N_CH-1:0] dbl;
    logic              found;

    // Lower copy masked below ptr, upper copy unmasked: the lowest set bit of
    // the doubled vector is the cyclic winner.
    always_comb begin
        dbl = {req, req};
        for (int i = 0; i < N_CH; i++) begin
            if (i < int'(ptr)) dbl[i] = 1'b0;
        end
        found   = 1'b0;
        gnt_idx = '0;
        for (int j = 0; j < 2 * N_CH; j++) begin
            if (!found && dbl[j]) begin
                found   = 1'b1;
                gnt_idx = IW'(j % N_CH);
            end
        end
        gnt = found ? (N_CH'(1) << gnt_idx) : '0;
        any = |req;
    end

endmodule

// File: rtl/tdc_pair_sched.sv
// Shares one pair-difference datapath between N_CH TDC channels: grant locks
// to a channel from its first word until its second word or a timeout.
module tdc_pair_sched
    import tdc_sched_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DW     = DW_DEF,
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         ch_req,
    input  logic [N_CH*DW-1:0]      ch_data,
    output logic [N_CH-1:0]         ch_ack,
    input  logic                    dp_busy,
    output logic                    dp_start,
    output logic [DW-1:0]           dp_a,
    output logic [DW-1:0]           dp_b,
    output logic [$clog2(N_CH)-1:0] dp_ch,
    output logic                    err_to,
    output logic [CNT_W-1:0]        pair_cnt,
    output logic [7:0]              to_cnt,
    output state_t                  dbg_state
);
    localparam int IW = $clog2(N_CH);
    localparam int TW = $clog2(TO_CYC);

    state_t           state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, cur_q, nxt_ptr, arb_idx;
    logic [N_CH-1:0]  arb_gnt;
    logic             arb_any;
    logic [TW-1:0]    timer_q;
    logic [DW-1:0]    dp_a_q, dp_b_q, data_g, data_cur;
    logic [CNT_W-1:0] pair_cnt_q;
    logic [7:0]       to_cnt_q;
    logic             err_to_q;
    logic             xfer_a, xfer_b, timer_done, to_hit, issue;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req     (ch_req),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    assign data_g     = ch_data[int'(arb_idx)*DW +: DW];
    assign data_cur   = ch_data[int'(cur_q)*DW +: DW];
    assign nxt_ptr    = (cur_q == IW'(N_CH - 1)) ? '0 : cur_q + IW'(1);
    assign timer_done = (timer_q == TW'(TO_CYC - 1));
    assign xfer_a     = (state_q == IDLE) && arb_any;
    assign xfer_b     = (state_q == WAIT_B) && ch_req[cur_q];
    assign to_hit     = (state_q == WAIT_B) && !ch_req[cur_q] && timer_done;
    assign issue      = (state_q == ISSUE) && !dp_busy;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer_a) state_d = WAIT_B;
            WAIT_B:  if (xfer_b) state_d = ISSUE;
                     else if (to_hit) state_d = IDLE;
            ISSUE:   if (issue) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ch_ack   = '0;
        dp_start = 1'b0;
        case (state_q)
            IDLE:    ch_ack = arb_gnt;
            WAIT_B:  ch_ack[cur_q] = ch_req[cur_q];
            ISSUE:   dp_start = !dp_busy;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            cur_q      <= '0;
            timer_q    <= '0;
            dp_a_q     <= '0;
            dp_b_q     <= '0;
            pair_cnt_q <= '0;
            to_cnt_q   <= '0;
            err_to_q   <= 1'b0;
        end else begin
            err_to_q <= to_hit;
            if (xfer_a) begin
                dp_a_q  <= data_g;
                cur_q   <= arb_idx;
                timer_q <= '0;
            end
            if ((state_q == WAIT_B) && !xfer_b && !timer_done) timer_q <= timer_q + TW'(1);
            if (xfer_b) dp_b_q <= data_cur;
            // The channel just served drops to lowest priority either way.
            if (to_hit) begin
                rr_ptr_q <= nxt_ptr;
                if (to_cnt_q != 8'hFF) to_cnt_q <= to_cnt_q + 8'd1;
            end
            if (issue) begin
                rr_ptr_q   <= nxt_ptr;
                pair_cnt_q <= pair_cnt_q + CNT_W'(1);
            end
        end
    end

    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign dp_ch     = cur_q;
    assign err_to    = err_to_q;
    assign pair_cnt  = pair_cnt_q;
    assign to_cnt    = to_cnt_q;
    assign dbg_state = state_q;

endmodule
